// File: rtl/alu_ctrl_arb.sv
// Two-port round-robin arbiter and sequencer for the shared 16-bit registered ALU.
// Traps illegal opcodes and divide-by-zero before issue; returns tagged responses.
module alu_ctrl_arb #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_data,
    output logic         resp_zero,
    output logic         resp_carry,
    output logic         resp_err,
    output logic         busy,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_fn,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zero,
    input  logic         alu_carry
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t       state_q, state_d;
    logic         ptr_q, ptr_d;
    logic         id_q, id_d;
    logic [3:0]   op_q, op_d;
    logic [W-1:0] alu_a_q, alu_a_d;
    logic [W-1:0] alu_b_q, alu_b_d;
    logic [3:0]   alu_fn_q, alu_fn_d;
    logic [W-1:0] data_q, data_d;
    logic         zero_q, zero_d;
    logic         carry_q, carry_d;
    logic         err_q, err_d;

    logic         gnt;
    logic [3:0]   sel_op;
    logic [W-1:0] sel_a, sel_b;
    logic         legal;

    always_comb begin
        // On a tie the port not granted last wins; otherwise whichever is valid.
        gnt    = (req0_valid && req1_valid) ? ~ptr_q : req1_valid;
        sel_op = gnt ? req1_op : req0_op;
        sel_a  = gnt ? req1_a  : req0_a;
        sel_b  = gnt ? req1_b  : req0_b;
        legal  = (sel_op <= 4'd8) && !((sel_op == 4'd3) && (sel_b == '0));
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        op_d       = op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fn_d   = alu_fn_q;
        data_d     = data_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    req0_ready = !gnt;
                    req1_ready = gnt;
                    ptr_d      = gnt;
                    id_d       = gnt;
                    op_d       = sel_op;
                    if (legal) begin
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        alu_fn_d = sel_op;
                        state_d  = EXEC;
                    end else begin
                        data_d  = '0;
                        zero_d  = 1'b0;
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                // ALU carry is sticky across non-add ops, so only trust it for add.
                data_d  = alu_out;
                zero_d  = alu_zero;
                carry_d = (op_q == 4'd0) ? alu_carry : 1'b0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b1;
            id_q     <= 1'b0;
            op_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_fn_q <= '0;
            data_q   <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_fn_q <= alu_fn_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign resp_zero  = zero_q;
    assign resp_carry = carry_q;
    assign resp_err   = err_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_fn     = alu_fn_q;

endmodule

// File: tb/tb_alu_ctrl_arb.sv
// Scoreboard bench for alu_ctrl_arb with a behavioural model of the registered ALU.
// Drivers push expected responses; a negedge monitor checks latency and payload.
module tb_alu_ctrl_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id;
    logic [15:0] resp_data;
    logic        resp_zero, resp_carry, resp_err, busy;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_fn;
    logic        alu_zero, alu_carry;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        zero;
        logic        carry;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];

    alu_ctrl_arb #(.W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_carry(resp_carry),
        .resp_err(resp_err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU: one-cycle latency, carry only updated by add (sticky otherwise).
    function automatic logic [16:0] alu_f(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (fn)
            4'd0: alu_f = {1'b0, a} + {1'b0, b};
            4'd1: alu_f = {1'b0, a - b};
            4'd2: begin p = a * b; alu_f = {1'b0, p[15:0]}; end
            4'd3: alu_f = (b != 0) ? {1'b0, a / b} : 17'd0;
            4'd4: alu_f = {1'b0, a & b};
            4'd5: alu_f = {1'b0, a | b};
            4'd6: alu_f = {1'b0, a ^ b};
            4'd7: alu_f = {1'b0, ~a};
            4'd8: alu_f = {1'b0, ~b};
            default: alu_f = 17'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [16:0] r;
        if (rst) begin
            alu_out   <= '0;
            alu_zero  <= 1'b0;
            alu_carry <= 1'b0;
        end else begin
            r = alu_f(alu_fn, alu_a, alu_b);
            alu_out  <= r[15:0];
            alu_zero <= (r[15:0] == 16'h0000);
            if (alu_fn == 4'd0) alu_carry <= r[16];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic id, input logic [15:0] data, input logic zero,
                        input logic carry, input logic err, input int lat);
        exp_t e;
        e.id = id; e.data = data; e.zero = zero; e.carry = carry; e.err = err; e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input bit p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bit ok = 0;
        if (!p) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else    begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((p ? req1_ready : req0_ready) === 1'b1) begin ok = 1; break; end
        end
        if (!ok) chk(p ? "accept_timeout_1" : "accept_timeout_0", 0, 1);
        @(posedge clk); #1;
        if (!p) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_id"},    resp_id, 0);
        chk({tag, "_resp_data"},  resp_data, 0);
        chk({tag, "_flags"},      {resp_zero, resp_carry, resp_err}, 0);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_readies"},    {req0_ready, req1_ready}, 0);
        chk({tag, "_alu_a"},      alu_a, 0);
        chk({tag, "_alu_b"},      alu_b, 0);
        chk({tag, "_alu_fn"},     alu_fn, 0);
    endtask

    // Monitor: latency measured from accept to first visible resp_valid.
    initial begin
        bit prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_q.delete();
                prev = 0;
            end else begin
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
                    acc_q.push_back(cyc);
                if (resp_valid && !prev) begin
                    chk("resp_expected", sb_q.size() > 0, 1);
                    chk("accept_seen", acc_q.size() > 0, 1);
                    if (sb_q.size() > 0 && acc_q.size() > 0)
                        chk("latency", cyc - acc_q.pop_front(), sb_q[0].lat);
                end
                if (resp_valid && resp_ready && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("resp_id",    resp_id, e.id);
                    chk("resp_data",  resp_data, e.data);
                    chk("resp_zero",  resp_zero, e.zero);
                    chk("resp_carry", resp_carry, e.carry);
                    chk("resp_err",   resp_err, e.err);
                end
                prev = resp_valid;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; resp_ready = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req0_a = 0; req0_b = 0;
        req1_op = 0; req1_a = 0; req1_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Add with carry-out
        push(0, 16'h0000, 1, 1, 0, 3);
        send(0, 4'd0, 16'hFFFF, 16'h0001);
        wait_drain();

        // AND after a carrying add: sticky ALU carry must be masked
        push(0, 16'h0000, 1, 0, 0, 3);
        send(0, 4'd4, 16'h00F0, 16'h0F00);
        wait_drain();

        // Divide-by-zero trap leaves the ALU inputs untouched
        push(1, 16'h0000, 0, 0, 1, 1);
        send(1, 4'd3, 16'd100, 16'd0);
        wait_drain();
        chk("trap_alu_a",  alu_a, 16'h00F0);
        chk("trap_alu_b",  alu_b, 16'h0F00);
        chk("trap_alu_fn", alu_fn, 4'd4);

        // Illegal opcode, then a legal divide
        push(0, 16'h0000, 0, 0, 1, 1);
        send(0, 4'hC, 16'h1234, 16'h5678);
        wait_drain();
        push(1, 16'd14, 0, 0, 0, 3);
        send(1, 4'd3, 16'd100, 16'd7);
        wait_drain();

        // Both ports continuously valid: strict 0,1,0,1 alternation
        push(0, 16'h0003, 0, 0, 0, 3);
        push(1, 16'h0000, 1, 0, 0, 3);
        push(0, 16'hFFFE, 0, 0, 0, 3);
        push(1, 16'hFFFF, 0, 0, 0, 3);
        fork
            begin send(0, 4'd0, 16'd1, 16'd2);      send(0, 4'd1, 16'd5, 16'd7); end
            begin send(1, 4'd2, 16'h0100, 16'h0100); send(1, 4'd6, 16'hAAAA, 16'h5555); end
        join
        wait_drain();

        // Back-pressure: hold the response 5 cycles with the other port waiting
        resp_ready = 1'b0;
        push(0, 16'h12CB, 0, 0, 0, 3);
        send(0, 4'd6, 16'h1234, 16'h00FF);
        push(1, 16'h0FFF, 0, 0, 0, 3);
        fork
            send(1, 4'd5, 16'h0F0F, 16'h00F0);
        join_none
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) break;
            @(posedge clk); #1;
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid",   resp_valid, 1);
            chk("bp_data",    resp_data, 16'h12CB);
            chk("bp_readies", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_drain();
        wait fork;

        // Reset in EXEC discards the op and restores reset values
        send(0, 4'd0, 16'd3, 16'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        rst = 1'b0;

        // Pointer is back at 1, so port 0 wins the first tie again
        push(0, 16'hFF00, 0, 0, 0, 3);
        push(1, 16'hFFFE, 0, 0, 0, 3);
        fork
            send(0, 4'd7, 16'h00FF, 16'h0000);
            send(1, 4'd8, 16'h0000, 16'h0001);
        join
        wait_drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
